// File: rtl/uart_cal_pkg.sv
// Shared types and constants for the UART calculator.
// Packet byte selection lives here so every unit agrees on byte order.
package uart_cal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic {
    ECHO = 1'b0,
    RES  = 1'b1
  } grant_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [2:0] MAX_LEN  = 3'd4;

  function automatic logic [2:0] clamp_len(
    input logic [2:0] len
  );
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  // Data bytes go MSB-first, then CR, then LF.
  function automatic logic [7:0] pick_byte(
    input logic [31:0] data,
    input logic [2:0]  len,
    input logic [2:0]  idx
  );
    logic [1:0]  sh;
    logic [31:0] s;
    sh = 2'd0;
    s  = 32'd0;
    if (idx < len) begin
      sh = 2'(len - idx - 3'd1);
      s  = data >> {sh, 3'b000};
      return s[7:0];
    end else if (idx == len) begin
      return ASCII_CR;
    end
    return ASCII_LF;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between echo and result requesters.
// Grant is combinational; last_grant updates only when enabled.
module rr_arb2
  import uart_cal_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic i_req_echo,
  input  logic i_req_res,
  input  logic i_upd,
  output logic o_gnt_echo,
  output logic o_gnt_res
);

  grant_t r_last;

  always_comb begin
    o_gnt_echo = i_req_echo &
                 (~i_req_res | (r_last == RES));
    o_gnt_res  = i_req_res &
                 (~i_req_echo | (r_last == ECHO));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_last <= RES;
    end else if (i_upd) begin
      if (o_gnt_echo) begin
        r_last <= ECHO;
      end else if (o_gnt_res) begin
        r_last <= RES;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: sequences echo bytes and result packets
// one byte at a time into the shared tx serializer.
module uart_tx_sched
  import uart_cal_pkg::*;
#(
  parameter bit EOL_EN  = 1'b1,
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        echo_req,
  input  logic [7:0]  echo_data,
  output logic        echo_ack,
  input  logic        res_req,
  input  logic [31:0] res_data,
  input  logic [2:0]  res_len,
  output logic        res_ack,
  output logic [7:0]  tx_data,
  output logic        uout_valid,
  input  logic        tx_valid,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_PRE = CW'(TIMEOUT - 2);

  state_t        r_state;
  logic [31:0]   r_data;
  logic [2:0]    r_len;
  logic [2:0]    r_idx;
  logic [2:0]    r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_echo_ack;
  logic          r_res_ack;
  logic          r_uv;
  logic [7:0]    r_txd;
  logic          r_busy;
  logic          r_err;

  state_t        w_state;
  logic [31:0]   w_data;
  logic [2:0]    w_len;
  logic [2:0]    w_idx;
  logic [2:0]    w_rem;
  logic [CW-1:0] w_cnt;
  logic          w_echo_ack;
  logic          w_res_ack;
  logic          w_uv;
  logic [7:0]    w_txd;
  logic          w_busy;
  logic          w_err;

  logic          w_gnt_echo;
  logic          w_gnt_res;
  logic [2:0]    w_res_len;
  logic          w_res_eol;

  rr_arb2 u_arb (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_req_echo (echo_req),
    .i_req_res  (res_req),
    .i_upd      (r_state == IDLE),
    .o_gnt_echo (w_gnt_echo),
    .o_gnt_res  (w_gnt_res)
  );

  assign w_res_len = clamp_len(res_len);
  assign w_res_eol = EOL_EN && (w_res_len != 3'd0);

  always_comb begin
    w_state    = r_state;
    w_data     = r_data;
    w_len      = r_len;
    w_idx      = r_idx;
    w_rem      = r_rem;
    w_cnt      = r_cnt;
    w_echo_ack = 1'b0;
    w_res_ack  = 1'b0;
    w_uv       = 1'b0;
    w_txd      = r_txd;
    w_err      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_echo) begin
          w_echo_ack = 1'b1;
          w_data     = {24'd0, echo_data};
          w_len      = 3'd1;
          w_idx      = 3'd0;
          w_rem      = 3'd1;
          w_cnt      = '0;
          w_uv       = 1'b1;
          w_txd      = echo_data;
          w_state    = SEND;
        end else if (w_gnt_res) begin
          w_res_ack = 1'b1;
          // Empty result: ack only, nothing queued.
          if (w_res_len != 3'd0) begin
            w_data  = res_data;
            w_len   = w_res_len;
            w_idx   = 3'd0;
            w_rem   = w_res_len +
                      (w_res_eol ? 3'd2 : 3'd0);
            w_cnt   = '0;
            w_uv    = 1'b1;
            w_txd   = pick_byte(res_data,
                                w_res_len, 3'd0);
            w_state = SEND;
          end
        end
      end
      SEND: begin
        if (r_cnt == TO_MAX) begin
          w_state = GAP;
          w_cnt   = '0;
          w_rem   = 3'd0;
          w_idx   = 3'd0;
        end else if (tx_valid) begin
          w_state = GAP;
          w_cnt   = '0;
          w_idx   = r_idx + 3'd1;
          w_rem   = (r_rem != 3'd0) ?
                    r_rem - 3'd1 : 3'd0;
        end else begin
          // err lines up with the last allowed cycle.
          w_uv  = 1'b1;
          w_cnt = r_cnt + 1'b1;
          w_err = (r_cnt == TO_PRE);
        end
      end
      GAP: begin
        if (r_rem != 3'd0) begin
          w_state = SEND;
          w_uv    = 1'b1;
          w_cnt   = '0;
          w_txd   = pick_byte(r_data, r_len, r_idx);
        end else begin
          w_state = IDLE;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_data     <= 32'd0;
      r_len      <= 3'd0;
      r_idx      <= 3'd0;
      r_rem      <= 3'd0;
      r_cnt      <= '0;
      r_echo_ack <= 1'b0;
      r_res_ack  <= 1'b0;
      r_uv       <= 1'b0;
      r_txd      <= 8'h00;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_data     <= w_data;
      r_len      <= w_len;
      r_idx      <= w_idx;
      r_rem      <= w_rem;
      r_cnt      <= w_cnt;
      r_echo_ack <= w_echo_ack;
      r_res_ack  <= w_res_ack;
      r_uv       <= w_uv;
      r_txd      <= w_txd;
      r_busy     <= w_busy;
      r_err      <= w_err;
    end
  end

  assign echo_ack   = r_echo_ack;
  assign res_ack    = r_res_ack;
  assign uout_valid = r_uv;
  assign tx_data    = r_txd;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: byte scoreboard fed by a tx model,
// vector table plus tie, reset and timeout sequences.
module tb_uart_tx_sched;

  logic        clk;
  logic        n_rst;
  logic        echo_req;
  logic [7:0]  echo_data;
  logic        echo_ack;
  logic        res_req;
  logic [31:0] res_data;
  logic [2:0]  res_len;
  logic        res_ack;
  logic [7:0]  tx_data;
  logic        uout_valid;
  logic        tx_valid;
  logic        busy;
  logic        err;

  logic        echo_req2;
  logic [7:0]  echo_data2;
  logic        echo_ack2;
  logic        res_req2;
  logic [31:0] res_data2;
  logic [2:0]  res_len2;
  logic        res_ack2;
  logic [7:0]  tx_data2;
  logic        uout_valid2;
  logic        tx_valid2;
  logic        busy2;
  logic        err2;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rise = 0;
  int tx_delay = 100;

  typedef struct packed {
    logic       first;
    logic [7:0] b;
  } exp_t;

  typedef struct {
    bit          is_res;
    logic [7:0]  ed;
    logic [31:0] rd;
    logic [2:0]  rl;
    int          n;
    logic [47:0] bv;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[10];

  uart_tx_sched #(.EOL_EN(1'b1), .TIMEOUT(200)) u_dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .echo_req   (echo_req),
    .echo_data  (echo_data),
    .echo_ack   (echo_ack),
    .res_req    (res_req),
    .res_data   (res_data),
    .res_len    (res_len),
    .res_ack    (res_ack),
    .tx_data    (tx_data),
    .uout_valid (uout_valid),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .err        (err)
  );

  uart_tx_sched #(.EOL_EN(1'b1), .TIMEOUT(50)) u_dut_to (
    .clk        (clk),
    .n_rst      (n_rst),
    .echo_req   (echo_req2),
    .echo_data  (echo_data2),
    .echo_ack   (echo_ack2),
    .res_req    (res_req2),
    .res_data   (res_data2),
    .res_len    (res_len2),
    .res_ack    (res_ack2),
    .tx_data    (tx_data2),
    .uout_valid (uout_valid2),
    .tx_valid   (tx_valid2),
    .busy       (busy2),
    .err        (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push_bytes(
    input logic [47:0] bv,
    input int          n
  );
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.first = (i == 0);
      e.b     = bv[47-8*i -: 8];
      exp_q.push_back(e);
    end
  endtask

  // Serializer model: pulses tx_valid tx_delay cycles after
  // uout_valid rises and scores each byte.
  initial begin : tx_model
    exp_t       e;
    logic [7:0] b;
    bit         ok;
    bit         ab;
    int         t0;
    tx_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (n_rst && uout_valid) begin
        b  = tx_data;
        t0 = cyc;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", b, e.b);
          if (!e.first)
            chk("byte_gap", t0 - last_rise, tx_delay + 2);
        end
        last_rise = t0;
        ok = 1'b1;
        ab = 1'b0;
        for (int i = 0; i < tx_delay && !ab; i++) begin
          @(negedge clk);
          if (!n_rst) ab = 1'b1;
          else if (!uout_valid || tx_data !== b) ok = 1'b0;
        end
        if (ab) begin
          exp_q.delete();
        end else begin
          chk("byte_hold", ok, 1);
          tx_valid = 1'b1;
          @(negedge clk);
          tx_valid = 1'b0;
          if (n_rst) chk("gap_low", uout_valid, 0);
        end
      end
    end
  end

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !uout_valid)
        done = 1'b1;
    end
    chk("idle_reached", done, 1);
    @(negedge clk);
  endtask

  task automatic req_echo(input logic [7:0] d);
    bit got;
    got       = 1'b0;
    echo_data = d;
    echo_req  = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (echo_ack) got = 1'b1;
    end
    echo_req = 1'b0;
    chk("echo_ack", got, 1);
    if (got) begin
      chk("echo_ack_res_quiet", res_ack, 0);
      chk("echo_grant_uv", uout_valid, 1);
      chk("echo_grant_busy", busy, 1);
      @(posedge clk);
      #1;
      chk("echo_ack_pulse", echo_ack, 0);
    end
  endtask

  task automatic req_res(
    input logic [31:0] d,
    input logic [2:0]  len,
    input bit          nonempty
  );
    bit got;
    got      = 1'b0;
    res_data = d;
    res_len  = len;
    res_req  = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (res_ack) got = 1'b1;
    end
    res_req = 1'b0;
    chk("res_ack", got, 1);
    if (got) begin
      chk("res_ack_echo_quiet", echo_ack, 0);
      chk("res_grant_uv", uout_valid, nonempty);
      chk("res_grant_busy", busy, nonempty);
      @(posedge clk);
      #1;
      chk("res_ack_pulse", res_ack, 0);
      chk("res_uv_after", uout_valid, nonempty);
    end
  endtask

  task automatic wait_ack(output bit e, output bit r);
    e = 1'b0;
    r = 1'b0;
    for (int i = 0; i < 2000 && !(e || r); i++) begin
      @(posedge clk);
      #1;
      e = echo_ack;
      r = res_ack;
    end
    chk("ack_seen", e || r, 1);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin : main
    bit e;
    bit r;
    bit bad;
    bit seen;
    tbl[0] = '{1'b0, 8'h41, 32'h0,        3'd0, 1, 48'h41_00_00_00_00_00};
    tbl[1] = '{1'b1, 8'h00, 32'h00313233, 3'd3, 5, 48'h31_32_33_0D_0A_00};
    tbl[2] = '{1'b1, 8'h00, 32'hCAFEF00D, 3'd0, 0, 48'h0};
    tbl[3] = '{1'b1, 8'h00, 32'hDEADBEEF, 3'd6, 6, 48'hDE_AD_BE_EF_0D_0A};
    tbl[4] = '{1'b1, 8'h00, 32'h11223344, 3'd4, 6, 48'h11_22_33_44_0D_0A};
    tbl[5] = '{1'b1, 8'h00, 32'h000000A5, 3'd1, 3, 48'hA5_0D_0A_00_00_00};
    tbl[6] = '{1'b1, 8'h00, 32'h0000BEEF, 3'd2, 4, 48'hBE_EF_0D_0A_00_00};
    tbl[7] = '{1'b0, 8'h0D, 32'h0,        3'd0, 1, 48'h0D_00_00_00_00_00};
    tbl[8] = '{1'b1, 8'h00, 32'h12345678, 3'd7, 6, 48'h12_34_56_78_0D_0A};
    tbl[9] = '{1'b1, 8'h00, 32'hA1B2C3D4, 3'd5, 6, 48'hA1_B2_C3_D4_0D_0A};

    n_rst      = 1'b1;
    echo_req   = 1'b0;
    echo_data  = 8'h00;
    res_req    = 1'b0;
    res_data   = 32'h0;
    res_len    = 3'd0;
    echo_req2  = 1'b0;
    echo_data2 = 8'h00;
    res_req2   = 1'b0;
    res_data2  = 32'h0;
    res_len2   = 3'd0;
    tx_valid2  = 1'b0;

    #2 n_rst = 1'b0;
    #1;
    chk("rst_echo_ack", echo_ack, 0);
    chk("rst_res_ack", res_ack, 0);
    chk("rst_uv", uout_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_rst_uv", uout_valid, 0);

    for (int k = 0; k < 10; k++) begin
      push_bytes(tbl[k].bv, tbl[k].n);
      if (tbl[k].is_res)
        req_res(tbl[k].rd, tbl[k].rl, tbl[k].n != 0);
      else
        req_echo(tbl[k].ed);
      wait_idle();
      chk("vec_busy_idle", busy, 0);
    end

    // Tie out of reset: echo, then result, then echo
    // again after the re-raised echo loses the second tie.
    do_reset();
    push_bytes(48'h55_00_00_00_00_00, 1);
    push_bytes(48'h37_0D_0A_00_00_00, 3);
    push_bytes(48'h55_00_00_00_00_00, 1);
    echo_data = 8'h55;
    res_data  = 32'h00000037;
    res_len   = 3'd1;
    echo_req  = 1'b1;
    res_req   = 1'b1;
    wait_ack(e, r);
    chk("tie1_echo", e, 1);
    chk("tie1_res", r, 0);
    echo_req = 1'b0;
    @(posedge clk);
    #1;
    echo_req = 1'b1;
    wait_ack(e, r);
    chk("tie2_res", r, 1);
    chk("tie2_echo", e, 0);
    res_req = 1'b0;
    wait_ack(e, r);
    chk("tie3_echo", e, 1);
    echo_req = 1'b0;
    wait_idle();

    // Reset in the middle of the second result byte.
    push_bytes(48'h41_42_43_0D_0A_00, 5);
    req_res(32'h00414243, 3'd3, 1'b1);
    repeat (120) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_uv", uout_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_data", tx_data, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    chk("midrst_flushed", exp_q.size(), 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_ack || echo_ack || uout_valid) seen = 1'b1;
    end
    chk("midrst_no_reack", seen, 0);
    push_bytes(48'h5A_00_00_00_00_00, 1);
    req_echo(8'h5A);
    wait_idle();

    // Timeout on the TIMEOUT=50 instance, tx_valid withheld.
    @(posedge clk);
    #1;
    res_data2 = 32'h01020304;
    res_len2  = 3'd4;
    res_req2  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (res_ack2) seen = 1'b1;
    end
    res_req2 = 1'b0;
    chk("to_ack", seen, 1);
    chk("to_first_byte", tx_data2, 8'h01);
    bad = 1'b0;
    for (int j = 1; j < 50; j++) begin
      if (err2 || !uout_valid2) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("to_no_early_err", bad, 0);
    chk("to_err_c50", err2, 1);
    chk("to_uv_c50", uout_valid2, 1);
    @(posedge clk);
    #1;
    chk("to_err_pulse", err2, 0);
    chk("to_gap_uv", uout_valid2, 0);
    @(posedge clk);
    #1;
    chk("to_idle_busy", busy2, 0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (uout_valid2 || err2) seen = 1'b1;
    end
    chk("to_discard", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
